uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: the send-direction counterpart of the board's UART receive path.
- Accepts bytes on a one-cycle write strobe into an internal FIFO and serialises them 8N1, LSB first, on `tx`.
- Sits between user logic (for example, loopback of received bytes) and the UART_TXD pin.
- Back-to-back frames are sent with no idle gap while the FIFO holds data.

Parameters:
- CLOCK_HZ, 15000000, `clk` frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- write  input  1  one-cycle strobe; pushes `data` when `full`=0.
- data  input  8  byte to transmit; sampled only when `write`=1.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- busy  output  1  FIFO non-empty OR FSM not in IDLE.
- tx  output  1  serial line; idle level is 1.

Behaviour:
- Reset is asynchronous, active-low; one clock. On reset assertion, immediately:
  - tx=1, busy=0, full=0, count=0;
  - FIFO pointers cleared; FSM forced to IDLE; baud counter=0.
  - Reset mid-frame aborts the frame; the line returns high with no stop bit.
- CLKS_PER_BIT = (CLOCK_HZ + BAUD_RATE/2) / BAUD_RATE, i.e. rounded to nearest. It is 130 at the default parameters.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reloaded to 0 on every bit boundary. Each line bit lasts exactly CLKS_PER_BIT cycles.
- FIFO:
  - write with full=0 stores `data` at the edge that samples it.
  - write with full=1 drops the byte silently, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves `count` unchanged.
  - Pointers wrap modulo DEPTH; `count` is a registered occupancy.
- FSM states: IDLE, START, DATA, STOP (PARITY is added when the optional feature is enabled).
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, go to START, and clear the baud counter.
  - START: tx=0 for one bit time, then go to DATA with bit index 0.
  - DATA: tx=shift[0]; shift right at each bit end. After bit index 7, go to STOP (or PARITY).
  - STOP: tx=1 for one bit time. At its end:
    - FIFO non-empty: pop and go directly to START (no idle bit);
    - otherwise go to IDLE.
- Latency: a write into an empty FIFO with the FSM in IDLE drives tx low from the 2nd rising edge after the edge that sampled the write.
- Frame length is 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- `tx` is driven from a register, so the output is glitch-free.
- busy falls on the same edge at which the FSM returns to IDLE with the FIFO empty.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for one bit time.
- Undefined:
  - No PARITY state; plain 8N1 framing.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum `tx_state_t`;
  - a function computing CLKS_PER_BIT from CLOCK_HZ and BAUD_RATE;
  - the constant DATA_BITS = 8.
- The uart_rx path imports the same package.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count) is natural and reusable.
- uart_tx_fifo instantiates `sync_fifo` and contains only the baud counter, the FSM and the shift register.

Test Plan (CLOCK_HZ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10, DEPTH=4):
- Write 0xA5 once:
  - tx low 2 edges after the write;
  - sampled line bits at bit centres are 0,1,0,1,0,0,1,0,1,1;
  - the frame lasts 100 cycles; busy is high for the frame, then 0.
- Write 0x01, 0x02, 0x03 on consecutive cycles:
  - three frames with the next start bit directly after each stop bit;
  - count goes 1,2,3, then falls as frames start;
  - total time busy is 300 cycles plus latency.
- Write 6 bytes (0x10..0x15) on consecutive cycles while idle:
  - full=1 after the 4th stored entry (the 1st byte is popped);
  - 0x15 is dropped;
  - exactly 5 frames are sent, carrying 0x10..0x14.
- Deassert resetn mid-DATA of 0xFF:
  - tx=1, busy=0, count=0 immediately;
  - after release, no further frame is sent.
- With UART_TX_PARITY_EN defined:
  - 0x07 is sent with parity bit 1 and a frame of 110 cycles;
  - 0x03 is sent with parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, bit-timing helper, word size.
// UART_TX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
`endif

  // Rounded to nearest so the line rate error stays within half a clock.
  function automatic int clks_per_bit(
    input int clock_hz,
    input int baud_rate
  );
    return (clock_hz + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and first-word fall-through.
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser on tx.
// Define UART_TX_PARITY_EN for an even-parity bit (8E1 framing).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ  = 15000000,
  parameter int BAUD_RATE = 115200,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       write,
  input  logic [7:0]                 data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       tx
);

  localparam int CPB = clks_per_bit(CLOCK_HZ, BAUD_RATE);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = $clog2(DATA_BITS);

  logic                 empty;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_dout;

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (write),
    .pop    (pop),
    .din    (data),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign bit_end = (cnt_q == CW'(CPB - 1));
  assign busy    = !empty || (state_q != IDLE);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pop) begin
      shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_dout;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model plus
// an independent line decoder sampling tx at bit centres.
module tb_uart_tx_fifo;

  localparam int CLOCK_HZ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 4;
  localparam int CPB      = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB       = 11;
`else
  localparam int NB       = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       write = 1'b0;
  logic [7:0] data = 8'h00;
  logic       full;
  logic [2:0] count;
  logic       busy;
  logic       tx;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLOCK_HZ  (CLOCK_HZ),
    .BAUD_RATE (BAUD),
    .DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .write  (write),
    .data   (data),
    .full   (full),
    .count  (count),
    .busy   (busy),
    .tx     (tx)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes wait in a queue; a frame occupies FRAME_CYC
  // cycles and the next one is taken as soon as the previous ends.
  logic [7:0]  q[$];
  logic [7:0]  expq[$];
  int          rem = 0;
  logic        tx_exp = 1'b1;
  logic [10:0] frame = '1;

  function automatic logic [10:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      expq.delete();
      rem = 0;
      tx_exp = 1'b1;
    end else begin
      int  pre;
      bit  do_pop;
      bit  do_push;
      pre = q.size();
      tx_exp = (rem > 0) ? frame[(FRAME_CYC - rem) / CPB] : 1'b1;
      do_pop = (rem <= 1) && (pre > 0);
      do_push = write && (pre < DEPTH);
      if (do_pop) begin
        frame = mk_frame(q[0]);
        expq.push_back(q.pop_front());
        rem = FRAME_CYC;
      end else if (rem > 0) begin
        rem--;
      end
      if (do_push) q.push_back(data);
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("tx", tx, tx_exp);
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("busy", busy, (q.size() > 0) || (rem > 0));
    end
  end

  int busy_cycles = 0;
  always @(negedge clk) if (busy) busy_cycles++;

  // Line decoder, independent of the model's cycle bookkeeping.
  bit          dact = 1'b0;
  int          dcnt = 0;
  int          rx_frames = 0;
  logic [10:0] rxs = '1;

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      dact = 1'b0;
    end else begin
      if (!dact && tx == 1'b0) begin
        dact = 1'b1;
        dcnt = 0;
      end else if (dact) begin
        dcnt++;
      end
      if (dact && (dcnt % CPB) == CPB / 2) begin
        rxs[dcnt / CPB] = tx;
        if (dcnt / CPB == NB - 1) begin
          dact = 1'b0;
          rx_frames++;
          chk("rx_start", rxs[0], 1'b0);
          chk("rx_stop", rxs[NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
          chk("rx_parity", rxs[9], ^rxs[8:1]);
`endif
          if (expq.size() == 0) chk("rx_extra", 1, 0);
          else chk("rx_byte", rxs[8:1], expq.pop_front());
        end
      end
    end
  end

  task automatic drain();
    int i;
    for (i = 0; i < 5000; i++) begin
      if (!busy && rem == 0 && !dact && q.size() == 0) break;
      @(negedge clk);
    end
    if (i == 5000) chk("drain_timeout", 1, 0);
    repeat (5) @(negedge clk);
  endtask

  int f0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: latency, busy length, one frame.
    f0 = rx_frames;
    busy_cycles = 0;
    write = 1'b1;
    data = 8'hA5;
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    chk("lat_edge1", tx, 1'b1);
    @(negedge clk);
    chk("lat_edge2", tx, 1'b0);
    drain();
    chk("a5_busy_len", busy_cycles, FRAME_CYC + 1);
    chk("a5_frames", rx_frames - f0, 1);

    // Three back-to-back frames.
    f0 = rx_frames;
    busy_cycles = 0;
    for (int i = 1; i <= 3; i++) begin
      write = 1'b1;
      data = 8'(i);
      @(negedge clk);
    end
    write = 1'b0;
    drain();
    chk("b2b_busy_len", busy_cycles, 3 * FRAME_CYC + 1);
    chk("b2b_frames", rx_frames - f0, 3);

    // Overflow: sixth byte is dropped.
    f0 = rx_frames;
    for (int i = 0; i < 6; i++) begin
      write = 1'b1;
      data = 8'h10 + 8'(i);
      @(negedge clk);
      if (i == 4) chk("ovf_full", full, 1'b1);
    end
    write = 1'b0;
    drain();
    chk("ovf_frames", rx_frames - f0, 5);

    // Reset in the middle of the data bits.
    write = 1'b1;
    data = 8'hFF;
    @(negedge clk);
    write = 1'b0;
    repeat (40) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", count, 0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    f0 = rx_frames;
    repeat (300) @(negedge clk);
    chk("abort_frames", rx_frames - f0, 0);

    // Parity-sensitive bytes.
    f0 = rx_frames;
    write = 1'b1;
    data = 8'h07;
    @(negedge clk);
    data = 8'h03;
    @(negedge clk);
    write = 1'b0;
    drain();
    chk("par_frames", rx_frames - f0, 2);

    // Random traffic with occasional bursts.
    for (int i = 0; i < 1500; i++) begin
      write = ($urandom_range(0, 99) < 6) || (i % 400 < 8);
      data = 8'($urandom);
      @(negedge clk);
    end
    write = 1'b0;
    drain();
    chk("rnd_pending", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
